cache_nway_ctrl: RTL

- Parametrised N-way set-associative cache with true-LRU replacement, a multi-beat refill state machine and saturating hit/miss counters.
- Sits between the pipeline memory stage and main memory.
- Write-through, no-write-allocate.
- Read misses stall the requester until the full line is refilled.

---
 rtl/cache_nway_ctrl.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/cache_nway_ctrl.sv
// N-way set-associative, write-through / no-write-allocate cache controller with
// true-LRU replacement, multi-beat refill and saturating hit/miss statistics.
module cache_nway_ctrl #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int WAYS   = 2,
    parameter int SETS   = 64,
    parameter int WORDS  = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              req_ready,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              mem_req_valid,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic              mem_rsp_valid,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              clr_stats,
    output logic [CNT_W-1:0]  hit_cnt,
    output logic [CNT_W-1:0]  miss_cnt,
    output logic [2:0]        dbg_state
);
    localparam int OFF_W = $clog2(WORDS);
    localparam int IDX_W = $clog2(SETS);
    localparam int WAY_W = $clog2(WAYS);
    localparam int AGE_W = WAY_W;
    localparam int TAG_W = ADDR_W - 1 - OFF_W - IDX_W;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_WR_MEM  = 3'd1;
    localparam logic [2:0] S_RF_REQ  = 3'd2;
    localparam logic [2:0] S_RF_FILL = 3'd3;
    localparam logic [2:0] S_RESP    = 3'd4;

    function automatic logic [WAYS-1:0][AGE_W-1:0] age_reset_row();
        logic [WAYS-1:0][AGE_W-1:0] row;
        for (int w = 0; w < WAYS; w++) row[w] = AGE_W'(w);
        return row;
    endfunction
    localparam logic [WAYS-1:0][AGE_W-1:0] AGE_ROW = age_reset_row();

    // Handshake: a request is taken on any rising edge where req_valid && req_ready;
    // memory requests are taken where mem_req_valid && mem_ready.
    logic [2:0]                              state_q;
    logic [ADDR_W-1:0]                       lat_addr_q;
    logic [DATA_W-1:0]                       lat_wdata_q;
    logic [WAY_W-1:0]                        lat_way_q;
    logic [OFF_W-1:0]                        beat_q;
    logic                                    hit_rsp_q;
    logic [DATA_W-1:0]                       rdata_q;
    logic [SETS-1:0][WAYS-1:0]               valid_q;
    logic [SETS-1:0][WAYS-1:0][AGE_W-1:0]    age_q;
    logic [TAG_W-1:0]                        tag_q [SETS][WAYS];
    logic [DATA_W-1:0]                       data_q [WAYS*SETS*WORDS];

    logic [OFF_W-1:0] req_off, lat_off;
    logic [IDX_W-1:0] req_idx, lat_idx, lru_idx;
    logic [TAG_W-1:0] req_tag, lat_tag;
    logic             hit, found_inv, accept, fill_beat, fill_done, lru_en, dwr_en;
    logic [WAY_W-1:0] hit_way, victim, lru_way;
    logic [WAY_W+IDX_W+OFF_W-1:0] rd_idx, dwr_idx;
    logic [DATA_W-1:0] dwr_data;
    logic [WAYS-1:0][AGE_W-1:0] age_row, age_row_next;

    assign req_off = req_addr[OFF_W:1];
    assign req_idx = req_addr[OFF_W+IDX_W:OFF_W+1];
    assign req_tag = req_addr[ADDR_W-1:OFF_W+IDX_W+1];
    assign lat_off = lat_addr_q[OFF_W:1];
    assign lat_idx = lat_addr_q[OFF_W+IDX_W:OFF_W+1];
    assign lat_tag = lat_addr_q[ADDR_W-1:OFF_W+IDX_W+1];

    always_comb begin
        hit       = 1'b0;
        hit_way   = '0;
        found_inv = 1'b0;
        victim    = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[req_idx][w] && tag_q[req_idx][w] == req_tag) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
            if (!valid_q[req_idx][w] && !found_inv) begin
                found_inv = 1'b1;
                victim    = WAY_W'(w);
            end
        end
        if (!found_inv) begin
            for (int w = 0; w < WAYS; w++) begin
                if (age_q[req_idx][w] == AGE_W'(WAYS - 1)) victim = WAY_W'(w);
            end
        end
    end

    assign accept    = req_valid && (state_q == S_IDLE);
    assign fill_beat = (state_q == S_RF_FILL) && mem_rsp_valid;
    assign fill_done = fill_beat && (beat_q == OFF_W'(WORDS - 1));
    assign rd_idx    = {hit_way, req_idx, req_off};

    // Only one of an IDLE hit and the final refill beat can occur in a cycle.
    assign lru_en  = (accept && hit) || fill_done;
    assign lru_idx = fill_done ? lat_idx : req_idx;
    assign lru_way = fill_done ? lat_way_q : hit_way;

    always_comb begin
        age_row      = age_q[lru_idx];
        age_row_next = age_row;
        for (int w = 0; w < WAYS; w++) begin
            if (WAY_W'(w) == lru_way) age_row_next[w] = '0;
            else if (age_row[w] < age_row[lru_way]) age_row_next[w] = age_row[w] + AGE_W'(1);
        end
    end

    always_comb begin
        dwr_en   = 1'b0;
        dwr_idx  = rd_idx;
        dwr_data = req_wdata;
        if (accept && req_we && hit) begin
            dwr_en = 1'b1;
        end else if (fill_beat) begin
            dwr_en   = 1'b1;
            dwr_idx  = {lat_way_q, lat_idx, beat_q};
            dwr_data = mem_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (dwr_en) data_q[dwr_idx] <= dwr_data;
        if (fill_done) tag_q[lat_idx][lat_way_q] <= lat_tag;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            lat_addr_q  <= '0;
            lat_wdata_q <= '0;
            lat_way_q   <= '0;
            beat_q      <= '0;
            hit_rsp_q   <= 1'b0;
            rdata_q     <= '0;
            valid_q     <= '0;
            age_q       <= {SETS{AGE_ROW}};
            hit_cnt     <= '0;
            miss_cnt    <= '0;
        end else begin
            hit_rsp_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        lat_addr_q  <= req_addr;
                        lat_wdata_q <= req_wdata;
                        lat_way_q   <= victim;
                        beat_q      <= '0;
                        if (req_we) begin
                            state_q <= S_WR_MEM;
                        end else if (hit) begin
                            hit_rsp_q <= 1'b1;
                            rdata_q   <= data_q[rd_idx];
                        end else begin
                            state_q <= S_RF_REQ;
                        end
                    end
                end
                S_WR_MEM:  if (mem_ready) state_q <= S_RESP;
                S_RF_REQ:  if (mem_ready) state_q <= S_RF_FILL;
                S_RF_FILL: begin
                    if (mem_rsp_valid) begin
                        beat_q <= beat_q + OFF_W'(1);
                        if (beat_q == lat_off) rdata_q <= mem_rdata;
                        if (fill_done) begin
                            valid_q[lat_idx][lat_way_q] <= 1'b1;
                            state_q <= S_RESP;
                        end
                    end
                end
                S_RESP:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
            if (lru_en) age_q[lru_idx] <= age_row_next;
            if (clr_stats) begin
                hit_cnt  <= '0;
                miss_cnt <= '0;
            end else if (accept) begin
                if (hit && hit_cnt != '1) hit_cnt <= hit_cnt + CNT_W'(1);
                if (!hit && miss_cnt != '1) miss_cnt <= miss_cnt + CNT_W'(1);
            end
        end
    end

    assign req_ready     = (state_q == S_IDLE);
    assign rsp_valid     = hit_rsp_q || (state_q == S_RESP);
    assign rsp_rdata     = rdata_q;
    assign mem_req_valid = (state_q == S_WR_MEM) || (state_q == S_RF_REQ);
    assign mem_we        = (state_q == S_WR_MEM);
    assign mem_addr      = (state_q == S_WR_MEM) ? (lat_addr_q & ~ADDR_W'(1)) :
                           (state_q == S_RF_REQ) ? {lat_addr_q[ADDR_W-1:OFF_W+1], {(OFF_W+1){1'b0}}} :
                           '0;
    assign mem_wdata     = (state_q == S_WR_MEM) ? lat_wdata_q : '0;
    assign dbg_state     = state_q;
endmodule
